ctrl_teclado: RTL and testbench

Keypad scan controller for the 4x4 matrix keypad. It drives the active-low column scan, synchronises and debounces the active-low row inputs, and encodes each debounced press as a 4-bit key code. Codes go to the consumer (display/command logic) over a valid/ready handshake, with optional FIFO buffering. It replaces free-running combinational scanning with a sequenced, press-once-per-touch front end.

---
 rtl/teclado_pkg.sv | 38 +++
 rtl/ctrl_teclado_if.sv | 9 +
 rtl/fifo_teclas.sv | 41 ++++
 rtl/ctrl_teclado.sv | 133 +++++++++++++
 tb/tb_ctrl_teclado.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/teclado_pkg.sv
// teclado_pkg: FSM states, key-code and column constants, and code/row/column helpers
// shared by the ctrl_teclado keypad scanner.
package teclado_pkg;

    typedef enum logic [1:0] {ESCANEO, REBOTE, ENCOLAR, SOLTAR} estado_t;

    localparam logic [3:0] TECLA_A   = 4'hA;
    localparam logic [3:0] TECLA_B   = 4'hB;
    localparam logic [3:0] TECLA_C   = 4'hC;
    localparam logic [3:0] TECLA_D   = 4'hD;
    localparam logic [3:0] TECLA_AST = 4'hE;
    localparam logic [3:0] TECLA_ALM = 4'hF;

    localparam logic [3:0] COL_0 = 4'b0111;
    localparam logic [3:0] COL_1 = 4'b1011;
    localparam logic [3:0] COL_2 = 4'b1101;
    localparam logic [3:0] COL_3 = 4'b1110;
    localparam logic [3:0] SIN_TECLA = 4'b1111;

    // Digits 1..9 sit row-major in columns 0..2 of rows 0..2; column 3 holds A..D.
    function automatic logic [3:0] codigo_tecla(input logic [1:0] fila_idx, input logic [1:0] col_idx);
        logic [3:0] digito;
        digito = 4'(fila_idx) * 4'd3 + 4'(col_idx) + 4'd1;
        return col_idx == 2'd3 ? TECLA_A + 4'(fila_idx) :
               fila_idx != 2'd3 ? digito :
               col_idx == 2'd0 ? TECLA_AST :
               col_idx == 2'd1 ? 4'd0 : TECLA_ALM;
    endfunction

    function automatic logic [1:0] fila_activa(input logic [3:0] f);
        return !f[3] ? 2'd0 : !f[2] ? 2'd1 : !f[1] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [3:0] col_onehot(input logic [1:0] col_idx);
        return col_idx == 2'd0 ? COL_0 : col_idx == 2'd1 ? COL_1 : col_idx == 2'd2 ? COL_2 : COL_3;
    endfunction

endpackage

// File: rtl/ctrl_teclado_if.sv
// ctrl_teclado_if: key-code valid/ready channel from the keypad scanner to its consumer.
interface ctrl_teclado_if;
    logic [3:0] tecla_codigo;
    logic       tecla_valida;
    logic       tecla_lista;
    logic       perdida;
    modport master (output tecla_codigo, output tecla_valida, output perdida, input tecla_lista);
    modport slave  (input tecla_codigo, input tecla_valida, input perdida, output tecla_lista);
endinterface

// File: rtl/fifo_teclas.sv
// fifo_teclas: synchronous 4-bit key-code FIFO; while empty the output keeps the last popped code.
module fifo_teclas #(
    parameter int PROF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] dato,
    output logic [3:0] cabeza,
    output logic       llena,
    output logic       vacia
);
    localparam int AW = $clog2(PROF);

    logic [3:0] mem [PROF];
    logic [AW:0] wr, rd;
    logic [3:0] ultimo;

    assign vacia = wr == rd;
    assign llena = wr == {~rd[AW], rd[AW-1:0]};
    assign cabeza = vacia ? ultimo : mem[rd[AW-1:0]];

    always_ff @(posedge clk)
        if (push)
            mem[wr[AW-1:0]] <= dato;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
            ultimo <= '0;
        end else begin
            if (push)
                wr <= wr + (AW+1)'(1);
            if (pop) begin
                rd <= rd + (AW+1)'(1);
                ultimo <= mem[rd[AW-1:0]];
            end
        end
endmodule

// File: rtl/ctrl_teclado.sv
// ctrl_teclado: 4x4 keypad scanner with debounce and one code per touch over valid/ready.
// Define CTRL_TECLADO_FIFO_EN to buffer codes in a FIFO_PROF-deep FIFO instead of one register.
module ctrl_teclado
    import teclado_pkg::*;
#(
    parameter int DIV_ESCANEO = 4,
    parameter int N_REBOTE = 4,
    parameter int FIFO_PROF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    ctrl_teclado_if.master salida
);
    localparam int DW = $clog2(DIV_ESCANEO);
    localparam int CW = $clog2(N_REBOTE + 1);
    localparam logic [DW-1:0] DIV_FIN = DW'(DIV_ESCANEO - 1);
    localparam logic [CW-1:0] CNT_FIN = CW'(N_REBOTE);

    estado_t estado, estado_n;
    logic [3:0] sinc, filas_s, patron, patron_n, codigo;
    logic [DW-1:0] div, div_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] col, col_n, fila, fila_n;
    logic encolar, push, pop, llena;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sinc <= SIN_TECLA;
            filas_s <= SIN_TECLA;
            estado <= ESCANEO;
            div <= '0;
            cnt <= '0;
            col <= '0;
            fila <= '0;
            patron <= SIN_TECLA;
        end else begin
            sinc <= filas;
            filas_s <= sinc;
            estado <= estado_n;
            div <= div_n;
            cnt <= cnt_n;
            col <= col_n;
            fila <= fila_n;
            patron <= patron_n;
        end

    // cnt counts matching samples in REBOTE and idle samples in SOLTAR.
    always_comb begin
        estado_n = estado;
        div_n = '0;
        cnt_n = cnt;
        col_n = col;
        fila_n = fila;
        patron_n = patron;
        case (estado)
            ESCANEO:
                if (div != DIV_FIN)
                    div_n = div + DW'(1);
                else if (filas_s != SIN_TECLA) begin
                    estado_n = REBOTE;
                    cnt_n = CW'(1);
                    patron_n = filas_s;
                    fila_n = fila_activa(filas_s);
                end else
                    col_n = col + 2'd1;
            REBOTE:
                if (filas_s != patron) begin
                    estado_n = ESCANEO;
                    col_n = col + 2'd1;
                end else if (cnt + CW'(1) == CNT_FIN)
                    estado_n = ENCOLAR;
                else
                    cnt_n = cnt + CW'(1);
            ENCOLAR: begin
                estado_n = SOLTAR;
                cnt_n = '0;
            end
            SOLTAR:
                if (filas_s != SIN_TECLA)
                    cnt_n = '0;
                else if (cnt + CW'(1) == CNT_FIN) begin
                    estado_n = ESCANEO;
                    col_n = col + 2'd1;
                end else
                    cnt_n = cnt + CW'(1);
            default: estado_n = ESCANEO;
        endcase
    end

    assign columnas = col_onehot(col);
    assign codigo = codigo_tecla(fila, col);
    assign encolar = estado == ENCOLAR;
    assign push = encolar && (!llena || pop);
    assign salida.perdida = encolar && !push;

`ifdef CTRL_TECLADO_FIFO_EN
    logic vacia;

    assign pop = !vacia && salida.tecla_lista;
    assign salida.tecla_valida = !vacia;

    fifo_teclas #(.PROF(FIFO_PROF)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .dato(codigo),
        .cabeza(salida.tecla_codigo),
        .llena(llena),
        .vacia(vacia)
    );
`else
    logic valida;
    logic [3:0] dato;

    assign pop = valida && salida.tecla_lista;
    assign llena = valida;
    assign salida.tecla_valida = valida;
    assign salida.tecla_codigo = dato;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valida <= 1'b0;
            dato <= '0;
        end else if (push) begin
            valida <= 1'b1;
            dato <= codigo;
        end else if (pop)
            valida <= 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_teclado.sv
// tb_ctrl_teclado: scoreboard bench driving ctrl_teclado from a behavioural 4x4 keypad model;
// expected codes come from the keypad legend table, checked by a handshake monitor.
module tb_ctrl_teclado;
    localparam int DIV = 4;
    localparam int NREB = 4;
    localparam int PROF = 4;
    localparam logic [3:0] TABLA [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic glitch = 1'b0;
    logic [3:0] filas, columnas;
    logic pulsada [4][4];
    logic [3:0] esperados [$];
    int checks = 0;
    int fails = 0;
    int perdidas = 0;
    logic mon_hold = 1'b0;
    logic [3:0] mon_prev = 4'h0;
    logic [3:0] mon_req;

    ctrl_teclado_if bus ();

    ctrl_teclado #(.DIV_ESCANEO(DIV), .N_REBOTE(NREB), .FIFO_PROF(PROF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .filas(filas),
        .columnas(columnas),
        .salida(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] col_ref(input int c);
        logic [3:0] v;
        v = 4'b1000 >> c;
        return ~v;
    endfunction

    // A pressed switch pulls its row low only while its column is driven.
    always_comb begin
        filas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pulsada[r][c] && columnas == col_ref(c))
                    filas[3-r] = 1'b0;
        if (glitch)
            filas = 4'b0111;
    end

    task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] requerido);
        checks++;
        if (actual !== requerido) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nombre, actual, requerido);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n)
            mon_hold = 1'b0;
        else begin
            if (mon_hold) begin
                check("hold_valida", bus.tecla_valida, 1);
                check("hold_codigo", bus.tecla_codigo, mon_prev);
            end
            if (bus.tecla_valida && bus.tecla_lista) begin
                if (esperados.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_key: got %0d, required none", bus.tecla_codigo);
                end else begin
                    mon_req = esperados.pop_front();
                    check("codigo", bus.tecla_codigo, mon_req);
                end
            end
            if (bus.perdida)
                perdidas++;
            mon_hold = bus.tecla_valida && !bus.tecla_lista;
            mon_prev = bus.tecla_codigo;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic ciclos(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic soltar();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pulsada[r][c] = 1'b0;
    endtask

    task automatic pulsar(input int r, input int c, input bit aceptada);
        pulsada[r][c] = 1'b1;
        if (aceptada)
            esperados.push_back(TABLA[r][c]);
    endtask

    task automatic tecla(input int r, input int c, input bit aceptada);
        pulsar(r, c, aceptada);
        ciclos(40);
        soltar();
        ciclos(20);
    endtask

    task automatic aplicar_reset();
        rst_n = 1'b0;
        glitch = 1'b0;
        soltar();
        esperados.delete();
    endtask

    task automatic liberar_reset();
        ciclos(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic esperar_col(input logic [3:0] objetivo);
        logic [3:0] previa;
        previa = columnas;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (columnas == objetivo && previa != objetivo)
                return;
            previa = columnas;
        end
        checks++;
        fails++;
        $display("FAIL column_timeout: got %b, required %b", columnas, objetivo);
    endtask

    task automatic drenar(input bit aleatorio);
        for (int i = 0; i < 400; i++) begin
            if (esperados.size() == 0)
                return;
            bus.tecla_lista = aleatorio ? 1'($urandom_range(0, 1)) : 1'b1;
            ciclos(1);
        end
        checks++;
        fails++;
        $display("FAIL drain_timeout: got %0d pending, required 0", esperados.size());
    endtask

    initial begin
        int n;
        int base;
        logic [3:0] previa;
        soltar();
        bus.tecla_lista = 1'b1;
        #2;
        aplicar_reset();
        #1;
        check("reset_columnas", columnas, 4'b0111);
        check("reset_valida", bus.tecla_valida, 0);
        check("reset_codigo", bus.tecla_codigo, 0);
        check("reset_perdida", bus.perdida, 0);
        liberar_reset();
        check("scan_col", columnas, 4'b0111);
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            check("scan_col", columnas, col_ref((k / DIV) % 4));
            check("scan_valida", bus.tecla_valida, 0);
        end

        // Key 5 held from reset: column 1 is sampled in the cycle ending at edge 2*DIV,
        // so the code becomes valid N_REBOTE cycles after that.
        bus.tecla_lista = 1'b0;
        aplicar_reset();
        pulsar(1, 1, 1);
        liberar_reset();
        n = 0;
        while (!bus.tecla_valida && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latencia", n, 2 * DIV + NREB);
        ciclos(10);
        check("codigo_5", bus.tecla_codigo, 4'h5);
        bus.tecla_lista = 1'b1;
        ciclos(1);
        bus.tecla_lista = 1'b0;
        @(negedge clk);
        check("valida_tras_pop", bus.tecla_valida, 0);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.tecla_valida)
                n++;
        end
        check("sin_repeticion", n, 0);
        soltar();
        ciclos(20);
        check("cola_tras_5", esperados.size(), 0);

        bus.tecla_lista = 1'b1;
        esperar_col(4'b1110);
        glitch = 1'b1;
        ciclos(3);
        glitch = 1'b0;
        previa = columnas;
        for (int k = 0; k < 60 && columnas == previa; k++)
            ciclos(1);
        check("col_tras_glitch", columnas, 4'b0111);
        ciclos(30);
        check("glitch_sin_codigo", bus.tecla_valida, 0);

        pulsar(0, 0, 1);
        pulsar(2, 0, 0);
        drenar(0);
        soltar();
        ciclos(20);

        base = perdidas;
        for (int k = 0; k < 12; k++) begin
            pulsar($urandom_range(0, 3), $urandom_range(0, 3), 1);
            drenar(1);
            soltar();
            ciclos(20);
        end
        check("aleatorio_perdidas", perdidas - base, 0);

        bus.tecla_lista = 1'b0;
        base = perdidas;
`ifdef CTRL_TECLADO_FIFO_EN
        tecla(0, 3, 1);
        tecla(1, 3, 1);
        tecla(2, 3, 1);
        tecla(3, 3, 1);
        tecla(3, 1, 0);
        check("cabeza_fifo", bus.tecla_codigo, 4'hA);
`else
        tecla(2, 0, 1);
        tecla(2, 1, 0);
        check("cabeza_reg", bus.tecla_codigo, 4'h7);
`endif
        check("perdida_lleno", perdidas - base, 1);
        check("valida_lleno", bus.tecla_valida, 1);
        drenar(0);
        ciclos(5);

        bus.tecla_lista = 1'b0;
        tecla(2, 0, 1);
        esperar_col(4'b0111);
        pulsar(2, 2, 0);
        esperar_col(4'b1101);
        ciclos(5);
        check("pre_reset_col", columnas, 4'b1101);
        check("pre_reset_codigo", bus.tecla_codigo, 4'h7);
        base = perdidas;
        aplicar_reset();
        #1;
        check("rst_columnas", columnas, 4'b0111);
        check("rst_valida", bus.tecla_valida, 0);
        check("rst_codigo", bus.tecla_codigo, 0);
        check("rst_perdida", bus.perdida, 0);
        liberar_reset();
        bus.tecla_lista = 1'b1;
        ciclos(40);
        check("post_rst_valida", bus.tecla_valida, 0);
        check("post_rst_perdidas", perdidas - base, 0);
        check("cola_final", esperados.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
